// File: rtl/data_router_lb_pkg.sv
// Shared types and helpers for the line-buffer data router.
package data_router_pkg;

  typedef enum logic [1:0] {
    RR = 2'b00,
    BR = 2'b01,
    RP = 2'b10,
    NE = 2'b11
  } rp_mode_e;

  // Index width for an n-entry dimension, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/data_router_lb_if.sv
// Write, command and output-beat bundle of the data router.
interface data_router_lb_if
  import data_router_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned POY  = 3,
  parameter int unsigned BUFW = 32,
  parameter int unsigned BUFH = 3
);
  localparam int unsigned BW = idx_w(POY);
  localparam int unsigned RW = idx_w(BUFH);
  localparam int unsigned CW = idx_w(BUFW);

  logic                                wr_en;
  logic [BW-1:0]                       wr_bank;
  logic [RW-1:0]                       wr_row;
  logic [BUFW-1:0][DW-1:0]             wr_data;

  logic                                cmd_valid;
  logic                                cmd_ready;
  logic [1:0]                          cmd_mode;
  logic [BW-1:0]                       cmd_bank;
  logic [RW-1:0]                       cmd_row;
  logic [CW-1:0]                       cmd_col;
  logic                                cmd_auto;
  logic                                cmd_last;

  logic                                out_valid;
  logic                                out_ready;
  logic [POY-1:0][BUFW-1:0][DW-1:0]    out_data;
  logic [POY-1:0]                      out_mask;
  logic                                blkend;
  logic                                err;

  modport slave (
    input  wr_en, wr_bank, wr_row, wr_data,
    input  cmd_valid, cmd_mode, cmd_bank, cmd_row, cmd_col, cmd_auto, cmd_last,
    output cmd_ready,
    output out_valid, out_data, out_mask, blkend, err,
    input  out_ready
  );

  modport master (
    output wr_en, wr_bank, wr_row, wr_data,
    output cmd_valid, cmd_mode, cmd_bank, cmd_row, cmd_col, cmd_auto, cmd_last,
    input  cmd_ready,
    input  out_valid, out_data, out_mask, blkend, err,
    output out_ready
  );
endinterface

// File: rtl/data_router_lb_mem.sv
// Banked line-buffer storage: one full-row write port, one shared-row read across all banks.
module data_router_lb_mem
  import data_router_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned POY  = 3,
  parameter int unsigned BUFW = 32,
  parameter int unsigned BUFH = 3,
  parameter int unsigned BW   = idx_w(POY),
  parameter int unsigned RW   = idx_w(BUFH)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en_i,
  input  logic [BW-1:0]                    wr_bank_i,
  input  logic [RW-1:0]                    wr_row_i,
  input  logic [BUFW-1:0][DW-1:0]          wr_data_i,
  input  logic [RW-1:0]                    rd_row_i,
  output logic [POY-1:0][BUFW-1:0][DW-1:0] rd_data_o
);

  logic [BUFW-1:0][DW-1:0] mem_q [POY][BUFH];

  // Row write; out-of-range bank/row addresses are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < POY; b++)
        for (int unsigned r = 0; r < BUFH; r++)
          mem_q[b][r] <= '0;
    end else if (wr_en_i && (32'(wr_bank_i) < POY) && (32'(wr_row_i) < BUFH)) begin
      mem_q[wr_bank_i][wr_row_i] <= wr_data_i;
    end
  end

  // Combinational read of the same row from every bank (pre-edge contents).
  always_comb begin
    rd_data_o = '0;
    if (32'(rd_row_i) < BUFH)
      for (int unsigned b = 0; b < POY; b++)
        rd_data_o[b] = mem_q[b][rd_row_i];
  end

endmodule

// File: rtl/data_router_lb.sv
// Line-buffer data router: command handshake, column pointer, registered output beat, pulses.
module data_router_lb
  import data_router_pkg::*;
#(
  parameter int unsigned DW     = 32,
  parameter int unsigned POY    = 3,
  parameter int unsigned BUFW   = 32,
  parameter int unsigned BUFH   = 3,
  parameter int unsigned STRIDE = 1
) (
  input logic             clk,
  input logic             rst_n,
  data_router_lb_if.slave bus
);
  localparam int unsigned BW = idx_w(POY);
  localparam int unsigned RW = idx_w(BUFH);
  localparam int unsigned CW = idx_w(BUFW);

  logic [POY-1:0][BUFW-1:0][DW-1:0] rd_data;
  logic [POY-1:0][BUFW-1:0][DW-1:0] out_data_q, out_data_d;
  logic [POY-1:0]                   out_mask_q, out_mask_d;
  logic                             out_valid_q, out_valid_d;
  logic                             last_q, last_d;
  logic                             blkend_q, blkend_d;
  logic                             err_q, err_d;
  logic [CW-1:0]                    colp_q, colp_d;

  rp_mode_e      mode;
  logic          accept, illegal, produce, consume;
  logic [CW-1:0] col;

  data_router_lb_mem #(
    .DW   (DW),
    .POY  (POY),
    .BUFW (BUFW),
    .BUFH (BUFH),
    .BW   (BW),
    .RW   (RW)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (bus.wr_en),
    .wr_bank_i (bus.wr_bank),
    .wr_row_i  (bus.wr_row),
    .wr_data_i (bus.wr_data),
    .rd_row_i  (bus.cmd_row),
    .rd_data_o (rd_data)
  );

  assign bus.cmd_ready = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_mask  = out_mask_q;
  assign bus.blkend    = blkend_q;
  assign bus.err       = err_q;

  // Command decode, legality check and next-state of the output beat and pointer.
  always_comb begin
    mode    = rp_mode_e'(bus.cmd_mode);
    accept  = bus.cmd_valid && bus.cmd_ready;
    consume = out_valid_q && bus.out_ready;
    col     = bus.cmd_auto ? colp_q : bus.cmd_col;
    illegal = (mode == NE)
           || ((mode == BR) && (32'(bus.cmd_bank) >= POY))
           || (32'(bus.cmd_row) >= BUFH)
           || ((mode == RP) && !bus.cmd_auto && (32'(bus.cmd_col) >= BUFW));
    produce = accept && !illegal;

    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    out_valid_d = produce ? 1'b1 : (consume ? 1'b0 : out_valid_q);
    last_d      = produce ? bus.cmd_last : (consume ? 1'b0 : last_q);
    blkend_d    = (consume && last_q) || (accept && illegal && bus.cmd_last);
    err_d       = accept && illegal;
    colp_d      = colp_q;

    if (produce) begin
      unique case (mode)
        RR: begin
          out_data_d = rd_data;
          out_mask_d = '1;
        end
        BR: begin
          out_data_d[bus.cmd_bank] = rd_data[bus.cmd_bank];
          out_mask_d               = '0;
          out_mask_d[bus.cmd_bank] = 1'b1;
        end
        RP: begin
          for (int unsigned i = 0; i < POY; i++)
            out_data_d[i][col] = rd_data[i][col];
          out_mask_d = '1;
        end
        default: ;
      endcase
      if ((mode == RP) && bus.cmd_auto)
        colp_d = CW'((32'(colp_q) + STRIDE) % BUFW);
    end
    // A block end clears the pointer after the command has used it.
    if (accept && bus.cmd_last)
      colp_d = '0;
  end

  // Output register, block tag, pulses and column pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_mask_q  <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      blkend_q    <= 1'b0;
      err_q       <= 1'b0;
      colp_q      <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
      blkend_q    <= blkend_d;
      err_q       <= err_d;
      colp_q      <= colp_d;
    end
  end

endmodule

// File: tb/tb_data_router_lb.sv
// Directed self-checking bench for data_router_lb (STRIDE=2).
module tb_data_router_lb;
  localparam int unsigned DW = 32, POY = 3, BUFW = 32, BUFH = 3;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  data_router_lb_if #(.DW(DW), .POY(POY), .BUFW(BUFW), .BUFH(BUFH)) bus ();

  data_router_lb #(
    .DW     (DW),
    .POY    (POY),
    .BUFW   (BUFW),
    .BUFH   (BUFH),
    .STRIDE (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [1:0] m, input logic [1:0] b, input logic [1:0] r,
                     input logic [4:0] c, input logic au, input logic la);
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = m;
    bus.cmd_bank  = b;
    bus.cmd_row   = r;
    bus.cmd_col   = c;
    bus.cmd_auto  = au;
    bus.cmd_last  = la;
  endtask

  task automatic idle();
    bus.cmd_valid = 1'b0;
    bus.cmd_auto  = 1'b0;
    bus.cmd_last  = 1'b0;
  endtask

  initial begin
    logic [BUFW-1:0][DW-1:0] row;
    int unsigned col;

    rst_n         = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_bank   = '0;
    bus.wr_row    = '0;
    bus.wr_data   = '0;
    bus.out_ready = 1'b0;
    bus.cmd_col   = '0;
    bus.cmd_bank  = '0;
    bus.cmd_row   = '0;
    bus.cmd_mode  = '0;
    idle();
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_mask", 32'(bus.out_mask), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_blkend", 32'(bus.blkend), 0);
    chk("rst_data", 32'(|bus.out_data), 0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    rst_n = 1'b1;

    // Preload mem[i][j][k] = 100i + j + k
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        for (int k = 0; k < 32; k++) row[k] = 32'(100 * i + j + k);
        bus.wr_en   = 1'b1;
        bus.wr_bank = 2'(i);
        bus.wr_row  = 2'(j);
        bus.wr_data = row;
        tick();
      end
    bus.wr_en = 1'b0;

    // RR row 2
    bus.out_ready = 1'b1;
    cmd(2'b00, 2'd0, 2'd2, 5'd0, 1'b0, 1'b0);
    tick(); idle();
    chk("rr_valid", 32'(bus.out_valid), 1);
    chk("rr_d15", bus.out_data[1][5], 107);
    chk("rr_d00", bus.out_data[0][0], 2);
    chk("rr_d231", bus.out_data[2][31], 233);
    chk("rr_mask", 32'(bus.out_mask), 7);

    // BR bank 2 row 0
    cmd(2'b01, 2'd2, 2'd0, 5'd0, 1'b0, 1'b0);
    tick(); idle();
    chk("br_d20", bus.out_data[2][0], 200);
    chk("br_d25", bus.out_data[2][5], 205);
    chk("br_d00_keep", bus.out_data[0][0], 2);
    chk("br_d15_keep", bus.out_data[1][5], 107);
    chk("br_mask", 32'(bus.out_mask), 4);

    // BR with bank out of range -> dropped, err pulse
    cmd(2'b01, 2'd3, 2'd0, 5'd0, 1'b0, 1'b0);
    tick(); idle();
    chk("brbad_err", 32'(bus.err), 1);
    chk("brbad_valid", 32'(bus.out_valid), 0);
    chk("brbad_d20", bus.out_data[2][0], 200);
    tick();
    chk("brbad_err_clr", 32'(bus.err), 0);

    // 17 auto RP on row 1 with stride 2: columns 0,2,...,30,0
    for (int n = 0; n < 17; n++) begin
      cmd(2'b10, 2'd0, 2'd1, 5'd0, 1'b1, 1'b0);
      tick();
      col = (2 * n) % 32;
      chk("rp_valid", 32'(bus.out_valid), 1);
      chk("rp_err", 32'(bus.err), 0);
      chk("rp_b0", bus.out_data[0][col], 1 + col);
      chk("rp_b2", bus.out_data[2][col], 201 + col);
    end
    idle();
    chk("rp_odd_keep", bus.out_data[1][1], 103);
    chk("rp_last_d00", bus.out_data[0][0], 1);
    chk("rp_mask", 32'(bus.out_mask), 7);

    // Non-auto RP row 0 col 7
    cmd(2'b10, 2'd0, 2'd0, 5'd7, 1'b0, 1'b0);
    tick();
    chk("rpc_d27", bus.out_data[2][7], 207);
    chk("rpc_d07", bus.out_data[0][7], 7);

    // Stall: RR row 0 pending while out_ready=0
    cmd(2'b00, 2'd0, 2'd0, 5'd0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    #1;
    chk("stall_ready0", 32'(bus.cmd_ready), 0);
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("stall_ready", 32'(bus.cmd_ready), 0);
      chk("stall_valid", 32'(bus.out_valid), 1);
      chk("stall_d27", bus.out_data[2][7], 207);
      chk("stall_d00", bus.out_data[0][0], 1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release_ready", 32'(bus.cmd_ready), 1);
    tick();
    chk("b2b0_valid", 32'(bus.out_valid), 1);
    chk("b2b0_d00", bus.out_data[0][0], 0);
    chk("b2b0_d15", bus.out_data[1][5], 105);
    cmd(2'b00, 2'd0, 2'd1, 5'd0, 1'b0, 1'b0);
    tick();
    chk("b2b1_valid", 32'(bus.out_valid), 1);
    chk("b2b1_d15", bus.out_data[1][5], 106);
    cmd(2'b01, 2'd0, 2'd2, 5'd0, 1'b0, 1'b0);
    tick(); idle();
    chk("b2b2_valid", 32'(bus.out_valid), 1);
    chk("b2b2_d00", bus.out_data[0][0], 2);
    chk("b2b2_d15", bus.out_data[1][5], 106);
    chk("b2b2_mask", 32'(bus.out_mask), 1);

    // NE with last: err + blkend next cycle, pointer reset
    cmd(2'b11, 2'd0, 2'd0, 5'd0, 1'b0, 1'b1);
    tick(); idle();
    chk("ne_err", 32'(bus.err), 1);
    chk("ne_blkend", 32'(bus.blkend), 1);
    chk("ne_valid", 32'(bus.out_valid), 0);
    tick();
    chk("ne_err_clr", 32'(bus.err), 0);
    chk("ne_blkend_clr", 32'(bus.blkend), 0);
    cmd(2'b10, 2'd0, 2'd0, 5'd0, 1'b1, 1'b0);
    tick(); idle();
    chk("colp0_d10", bus.out_data[1][0], 100);
    chk("colp0_d12", bus.out_data[1][2], 103);
    chk("colp0_err", 32'(bus.err), 0);

    // Write and read of the same row on one edge: beat sees old contents
    for (int k = 0; k < 32; k++) row[k] = 32'd999;
    cmd(2'b00, 2'd0, 2'd0, 5'd0, 1'b0, 1'b0);
    bus.wr_en   = 1'b1;
    bus.wr_bank = 2'd0;
    bus.wr_row  = 2'd0;
    bus.wr_data = row;
    tick(); idle();
    bus.wr_en = 1'b0;
    chk("coll_old", bus.out_data[0][4], 4);
    cmd(2'b00, 2'd0, 2'd0, 5'd0, 1'b0, 1'b0);
    tick(); idle();
    chk("coll_new", bus.out_data[0][4], 999);
    chk("coll_other", bus.out_data[1][4], 104);

    // Producing command with last: blkend after the beat is consumed
    cmd(2'b10, 2'd0, 2'd2, 5'd3, 1'b0, 1'b1);
    tick(); idle();
    chk("last_valid", 32'(bus.out_valid), 1);
    chk("last_d03", bus.out_data[0][3], 5);
    chk("last_blk_early", 32'(bus.blkend), 0);
    tick();
    chk("last_blkend", 32'(bus.blkend), 1);
    chk("last_valid_clr", 32'(bus.out_valid), 0);
    tick();
    chk("last_blk_clr", 32'(bus.blkend), 0);

    // Reset while a last-tagged beat is stalled
    bus.out_ready = 1'b0;
    cmd(2'b00, 2'd0, 2'd1, 5'd0, 1'b0, 1'b1);
    tick(); idle();
    chk("rstmid_valid", 32'(bus.out_valid), 1);
    chk("rstmid_d15", bus.out_data[1][5], 106);
    tick();
    chk("rstmid_blk0", 32'(bus.blkend), 0);
    rst_n = 1'b0;
    #2;
    chk("rstmid_valid_clr", 32'(bus.out_valid), 0);
    chk("rstmid_data_clr", bus.out_data[1][5], 0);
    chk("rstmid_mask_clr", 32'(bus.out_mask), 0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("rstmid_no_blkend", 32'(bus.blkend), 0);
    end
    cmd(2'b00, 2'd0, 2'd2, 5'd0, 1'b0, 1'b0);
    tick(); idle();
    chk("postrst_valid", 32'(bus.out_valid), 1);
    chk("postrst_mem_clr", bus.out_data[1][5], 0);
    chk("postrst_mask", 32'(bus.out_mask), 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_router_lb.md
Name: data_router_lb

Overview:
- Parametrised line-buffer data router that feeds the PE array.
- Holds POY banks × BUFH rows × BUFW words of feature data, written one full row per cycle by the buffer loader.
- Serves row, bank-row and pixel read commands through a valid/ready command port and a registered valid/ready output port.
- Adds an auto-advancing column pointer (stride-aware), error reporting and a block-end pulse. This replaces the free-running, non-handshaked router.

Parameters:
- DW, 32, data word width.
- POY, 3, number of banks (output rows).
- BUFW, 32, words per buffer row.
- BUFH, 3, rows per bank.
- STRIDE, 1, column-pointer increment for auto RP commands (legal values 1 and 2).
- BW = $clog2(POY), RW = $clog2(BUFH), CW = $clog2(BUFW): derived index widths; each has a minimum of 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  write one row.
- wr_bank  in  BW  destination bank.
- wr_row  in  RW  destination row.
- wr_data  in  [DW-1:0][BUFW]  row payload.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_mode  in  2  RR=00, BR=01, RP=10, NE=11.
- cmd_bank  in  BW  bank (BR only).
- cmd_row  in  RW  row index.
- cmd_col  in  CW  column (RP when cmd_auto=0).
- cmd_auto  in  1  RP uses internal column pointer.
- cmd_last  in  1  last command of block.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts beat.
- out_data  out  [DW-1:0] [POY][BUFW]  routed data.
- out_mask  out  POY  banks updated by this beat.
- blkend  out  1  one-cycle pulse, last beat of block consumed.
- err  out  1  one-cycle pulse, illegal command dropped.

Behaviour:
- Reset values (async, while rst_n=0): out_valid=0, out_data all 0, out_mask=0, blkend=0, err=0, column pointer colp=0, last-flag=0, storage all 0.
- Write: on a wr_en edge, mem[wr_bank][wr_row] <= wr_data. Writes with wr_bank>=POY or wr_row>=BUFH are ignored.
- Handshake: cmd_ready = !out_valid || out_ready (single output register, no bubble).
  - A command is accepted on any edge with cmd_valid&cmd_ready.
  - If a beat results, out_valid=1 on the next cycle, i.e. latency 1.
  - out_data, out_mask and out_valid hold stable while out_valid&!out_ready.
- Read/write collision: reads use storage contents before the edge. A write to the same row on the accept edge is not visible in that beat.
- RR: out_data[i] <= mem[i][cmd_row] for all i; out_mask = all ones.
- BR: out_data[cmd_bank] <= mem[cmd_bank][cmd_row]; other banks retain their previous values; out_mask is one-hot at cmd_bank.
- RP: c = cmd_auto ? colp : cmd_col.
  - out_data[i][c] <= mem[i][cmd_row][c] for all i; all other words retain their previous values; out_mask = all ones.
  - With cmd_auto=1, colp <= (colp+STRIDE) mod BUFW after accept. A wrap produces no beat and no error.
- NE, cmd_bank>=POY (BR), cmd_row>=BUFH, or non-auto cmd_col>=BUFW:
  - The command is accepted and no beat is produced; out_valid/out_data are unchanged.
  - err=1 for exactly the next cycle.
- cmd_last:
  - Accepted with a producing command: that beat is tagged last. blkend=1 for one cycle, on the cycle after the tagged beat's out_valid&out_ready handshake.
  - Accepted with a dropped command: blkend pulses on the cycle after acceptance.
  - Any accepted cmd_last resets colp to 0 after its own use.
- Simultaneous events: a new accept on the same edge a beat is consumed is legal and keeps out_valid=1. A write and a command to different rows on the same edge are independent.
- Reset asserted mid-block clears the in-flight beat, the pending last-tag and colp. No blkend is emitted for the aborted block.

Decomposition:
- data_router_pkg:
  - enum rp_mode_e {RR, BR, RP, NE} (2-bit).
  - Index-width helper function (clog2 with minimum 1).
- Sub-module data_router_lb_mem:
  - POY×BUFH×BUFW×DW register array with the row write port.
  - Combinational read of one row per bank at a shared row index.
- Top level holds the handshake, the colp counter, the output register and the blkend/err pulses.

Test Plan:
- Preload with mem[i][j][k]=100i+j+k (defaults); RR row=2, out_ready=1 -> after 1 cycle out_valid=1, out_data[1][5]=107, out_mask=3'b111.
- BR bank=2 row=0 after the RR above -> out_data[2][0]=200, out_data[0][0] unchanged at 2, out_mask=3'b100.
- STRIDE=2, BUFW=32: 17 RP auto commands row=1 -> columns 0,2,...,30,0 are updated; the 17th beat writes out_data[0][0]=1 and no err.
- out_ready held 0 for 4 cycles with cmd_valid=1 -> cmd_ready=0, out_data stable. Release -> one command is accepted per cycle back-to-back with no bubble.
- NE command with cmd_last=1 -> no beat; err=1 and blkend=1 for one cycle the cycle after accept; colp returns to 0.
- rst_n pulled low while a last-tagged beat is stalled -> out_valid=0 immediately; no blkend after rst_n rises.
